pipelined_add_sub: RTL and testbench



---
 rtl/pipelined_add_sub_if.sv | 35 +++
 rtl/pipelined_add_sub.sv | 122 ++++++++++++
 tb/tb_pipelined_add_sub.sv | 395 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipelined_add_sub_if.sv
// Bus bundle for the pipelined adder/subtractor: operation request side and
// result side.
//
// Handshake: a side with something to offer raises valid and holds its
// payload; the other side raises ready when it can take it. A transfer
// happens on a rising clock edge where valid && ready are both high.
// Request side transfers on i_valid && o_ready. Result side transfers on
// o_valid && i_ready.
interface pipelined_add_sub_if #(
  parameter int DATA_WD = 8
);
  logic               i_valid;
  logic               o_ready;
  logic [DATA_WD-1:0] i_a;
  logic [DATA_WD-1:0] i_b;
  logic               i_c;
  logic               i_sub;
  logic               o_valid;
  logic               i_ready;
  logic [DATA_WD:0]   o_arith_out;
  logic               o_ovf;
  logic               o_busy;

  // The arithmetic block receives operations and produces results
  modport slave (
    input  i_valid, i_a, i_b, i_c, i_sub, i_ready,
    output o_ready, o_valid, o_arith_out, o_ovf, o_busy
  );

  // The environment issues operations and consumes results
  modport master (
    output i_valid, i_a, i_b, i_c, i_sub, i_ready,
    input  o_ready, o_valid, o_arith_out, o_ovf, o_busy
  );
endinterface

// File: rtl/pipelined_add_sub.sv
// Pipelined adder/subtractor. The DATA_WD-bit operation is cut into
// NUM_STAGES slices of SL bits; stage k resolves slice k using the carry
// registered by stage k-1. Every rank carries its operation's full operands,
// partial result, carry and mode, so nothing is shared between operations.
// The whole pipeline advances together on en = !o_valid || i_ready.
module pipelined_add_sub #(
  parameter int DATA_WD    = 8,
  parameter int NUM_STAGES = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  pipelined_add_sub_if.slave   bus
);
  localparam int SL   = DATA_WD / NUM_STAGES;
  localparam int LAST = NUM_STAGES - 1;

  // Rank registers; index k is the output of stage k
  logic [NUM_STAGES-1:0] valid_q, valid_d;
  logic [NUM_STAGES-1:0] carry_q, carry_d;
  logic [NUM_STAGES-1:0] sub_q, sub_d;
  logic [DATA_WD-1:0]    a_q   [NUM_STAGES];
  logic [DATA_WD-1:0]    a_d   [NUM_STAGES];
  logic [DATA_WD-1:0]    bp_q  [NUM_STAGES];
  logic [DATA_WD-1:0]    bp_d  [NUM_STAGES];
  logic [DATA_WD-1:0]    sum_q [NUM_STAGES];
  logic [DATA_WD-1:0]    sum_d [NUM_STAGES];

  // Inputs seen by each stage (stage 0 from the bus, others from rank k-1)
  logic                  in_valid [NUM_STAGES];
  logic                  in_carry [NUM_STAGES];
  logic                  in_sub   [NUM_STAGES];
  logic [DATA_WD-1:0]    in_a     [NUM_STAGES];
  logic [DATA_WD-1:0]    in_bp    [NUM_STAGES];
  logic [DATA_WD-1:0]    in_sum   [NUM_STAGES];
  logic [SL:0]           slice_sum [NUM_STAGES];

  logic en;

  assign en          = !valid_q[LAST] || bus.i_ready;
  assign bus.o_ready = en;

  // Route each stage's operation: subtraction is folded into B' and cin here
  always_comb begin
    for (int k = 0; k < NUM_STAGES; k++) begin
      in_valid[k] = 1'b0;
      in_carry[k] = 1'b0;
      in_sub[k]   = 1'b0;
      in_a[k]     = '0;
      in_bp[k]    = '0;
      in_sum[k]   = '0;
    end
    in_valid[0] = bus.i_valid;
    in_a[0]     = bus.i_a;
    in_bp[0]    = bus.i_sub ? ~bus.i_b : bus.i_b;
    in_carry[0] = bus.i_sub ? ~bus.i_c : bus.i_c;
    in_sub[0]   = bus.i_sub;
    for (int k = 1; k < NUM_STAGES; k++) begin
      in_valid[k] = valid_q[k-1];
      in_a[k]     = a_q[k-1];
      in_bp[k]    = bp_q[k-1];
      in_carry[k] = carry_q[k-1];
      in_sub[k]   = sub_q[k-1];
      in_sum[k]   = sum_q[k-1];
    end
  end

  // Per-stage slice add; data only loads for a real operation so outputs
  // keep their last value while bubbles pass
  always_comb begin
    valid_d = valid_q;
    carry_d = carry_q;
    sub_d   = sub_q;
    for (int k = 0; k < NUM_STAGES; k++) begin
      slice_sum[k] = {1'b0, in_a[k][k*SL +: SL]} + {1'b0, in_bp[k][k*SL +: SL]}
                   + {{SL{1'b0}}, in_carry[k]};
      a_d[k]   = a_q[k];
      bp_d[k]  = bp_q[k];
      sum_d[k] = sum_q[k];
      if (en) begin
        valid_d[k] = in_valid[k];
      end
      if (en && in_valid[k]) begin
        a_d[k]              = in_a[k];
        bp_d[k]             = in_bp[k];
        sub_d[k]            = in_sub[k];
        carry_d[k]          = slice_sum[k][SL];
        sum_d[k]            = in_sum[k];
        sum_d[k][k*SL +: SL] = slice_sum[k][SL-1:0];
      end
    end
  end

  // Pipeline ranks; asynchronous reset discards everything in flight
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_q <= '0;
      carry_q <= '0;
      sub_q   <= '0;
      for (int k = 0; k < NUM_STAGES; k++) begin
        a_q[k]   <= '0;
        bp_q[k]  <= '0;
        sum_q[k] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      carry_q <= carry_d;
      sub_q   <= sub_d;
      for (int k = 0; k < NUM_STAGES; k++) begin
        a_q[k]   <= a_d[k];
        bp_q[k]  <= bp_d[k];
        sum_q[k] <= sum_d[k];
      end
    end
  end

  // Final carry is reported as a borrow in subtract mode; overflow uses B'
  assign bus.o_valid     = valid_q[LAST];
  assign bus.o_arith_out = {(sub_q[LAST] ? ~carry_q[LAST] : carry_q[LAST]), sum_q[LAST]};
  assign bus.o_ovf       = (a_q[LAST][DATA_WD-1] == bp_q[LAST][DATA_WD-1])
                        && (sum_q[LAST][DATA_WD-1] != a_q[LAST][DATA_WD-1]);
  assign bus.o_busy      = |valid_q;
endmodule

// File: tb/tb_pipelined_add_sub.sv
// Bench for pipelined_add_sub: four 8-bit instances (1, 2, 4, 8 stages)
// share one stimulus bus, each with its own expected queue; a 16-bit
// 4-stage instance covers long carry chains.
`timescale 1ns/1ps
module tb_pipelined_add_sub;
  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // shared 8-bit stimulus
  logic       drv_valid = 1'b0;
  logic       drv_ready = 1'b1;
  logic       drv_c     = 1'b0;
  logic       drv_sub   = 1'b0;
  logic [7:0] drv_a     = '0;
  logic [7:0] drv_b     = '0;

  // 16-bit stimulus
  logic        d16_valid = 1'b0;
  logic        d16_c     = 1'b0;
  logic        d16_sub   = 1'b0;
  logic [15:0] d16_a     = '0;
  logic [15:0] d16_b     = '0;

  // Reference: plain integer arithmetic. Returns {ovf, carry/borrow, result}
  // with the result in the low w bits.
  function automatic logic [17:0] ref_model(input int w, input logic [15:0] a,
                                            input logic [15:0] b, input logic c,
                                            input logic sub);
    longint m, ua, ub, sa, sb, r, sr, cy, ovf;
    m  = longint'(1) << w;
    ua = longint'(a);
    ub = longint'(b);
    sa = (ua >= m / 2) ? ua - m : ua;
    sb = (ub >= m / 2) ? ub - m : ub;
    if (!sub) begin
      r  = ua + ub + longint'(c);
      sr = sa + sb + longint'(c);
      cy = (r >= m) ? 1 : 0;
    end else begin
      r  = ua - ub - longint'(c);
      sr = sa - sb - longint'(c);
      cy = (r < 0) ? 1 : 0;
    end
    ovf = (sr < -(m / 2) || sr >= m / 2) ? 1 : 0;
    r   = r & (m - 1);
    return 18'((ovf << (w + 1)) | (cy << w) | r);
  endfunction

  // ---------------- 8-bit DUTs with scoreboards ----------------
  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int NS = 1 << g;
    pipelined_add_sub_if #(.DATA_WD(8)) bus ();
    logic [9:0] exp_q[$];
    logic [9:0] exp_v;
    logic [9:0] held;
    logic       stalled = 1'b0;
    int         out_cnt = 0;
    int         pending = 0;

    assign bus.i_valid = drv_valid;
    assign bus.i_a     = drv_a;
    assign bus.i_b     = drv_b;
    assign bus.i_c     = drv_c;
    assign bus.i_sub   = drv_sub;
    assign bus.i_ready = drv_ready;

    pipelined_add_sub #(.DATA_WD(8), .NUM_STAGES(NS)) u_dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus.slave)
    );

    always @(negedge clk) begin
      if (!rst_n) begin
        exp_q.delete();
        stalled = 1'b0;
        n_checks++;
        if ({bus.o_valid, bus.o_busy, bus.o_ovf, bus.o_arith_out} !== 12'd0) begin
          n_fail++;
          $display("FAIL reset_outputs ns=%0d: got valid=%b busy=%b ovf=%b out=%h, expected all 0",
                   NS, bus.o_valid, bus.o_busy, bus.o_ovf, bus.o_arith_out);
        end
      end else begin
        n_checks++;
        if (bus.o_ready !== !(bus.o_valid && !bus.i_ready)) begin
          n_fail++;
          $display("FAIL o_ready_rule ns=%0d: got %b, expected %b", NS, bus.o_ready,
                   !(bus.o_valid && !bus.i_ready));
        end
        n_checks++;
        if (bus.o_busy !== (exp_q.size() != 0)) begin
          n_fail++;
          $display("FAIL busy ns=%0d: got %b, expected %b", NS, bus.o_busy, exp_q.size() != 0);
        end
        if (stalled) begin
          n_checks++;
          if ({bus.o_valid, bus.o_ovf, bus.o_arith_out} !== {1'b1, held}) begin
            n_fail++;
            $display("FAIL stall_hold ns=%0d: got valid=%b val=%h, expected valid=1 val=%h",
                     NS, bus.o_valid, {bus.o_ovf, bus.o_arith_out}, held);
          end
        end
        if (bus.o_valid && bus.i_ready) begin
          n_checks++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_output ns=%0d: got %h, expected no result", NS,
                     {bus.o_ovf, bus.o_arith_out});
          end else begin
            exp_v = exp_q.pop_front();
            out_cnt++;
            if ({bus.o_ovf, bus.o_arith_out} !== exp_v) begin
              n_fail++;
              $display("FAIL result ns=%0d: got {ovf,out}=%h, expected %h", NS,
                       {bus.o_ovf, bus.o_arith_out}, exp_v);
            end
          end
        end
        if (bus.i_valid && bus.o_ready)
          exp_q.push_back(10'(ref_model(8, {8'h00, bus.i_a}, {8'h00, bus.i_b}, bus.i_c, bus.i_sub)));
        stalled = bus.o_valid && !bus.i_ready;
        held    = {bus.o_ovf, bus.o_arith_out};
      end
      pending = exp_q.size();
    end
  end

  // ---------------- 16-bit DUT ----------------
  pipelined_add_sub_if #(.DATA_WD(16)) bus16 ();
  assign bus16.i_valid = d16_valid;
  assign bus16.i_a     = d16_a;
  assign bus16.i_b     = d16_b;
  assign bus16.i_c     = d16_c;
  assign bus16.i_sub   = d16_sub;
  assign bus16.i_ready = 1'b1;

  pipelined_add_sub #(.DATA_WD(16), .NUM_STAGES(4)) u_dut16 (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus16.slave)
  );

  // ---------------- driver tasks ----------------
  task automatic drive_op(input logic [7:0] a, input logic [7:0] b,
                          input logic c, input logic sub);
    @(posedge clk); #1;
    drv_valid = 1'b1; drv_a = a; drv_b = b; drv_c = c; drv_sub = sub;
    @(posedge clk); #1;
    drv_valid = 1'b0;
  endtask

  task automatic drive_rand;
    drv_a   = 8'($urandom);
    drv_b   = 8'($urandom);
    drv_c   = 1'($urandom_range(0, 1));
    drv_sub = 1'($urandom_range(0, 1));
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    #1;
    n_checks++;
    if (g_dut[1].bus.o_ready !== 1'b1 || g_dut[1].bus.o_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: got ready=%b valid=%b, expected ready=1 valid=0",
               g_dut[1].bus.o_ready, g_dut[1].bus.o_valid);
    end
    // stream a few operations, then reset while they are in flight
    drv_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      drv_valid = 1'b1; drive_rand();
      d16_valid = 1'b1; d16_a = 16'($urandom); d16_b = 16'($urandom);
    end
    @(posedge clk); #1;
    drv_valid = 1'b0; d16_valid = 1'b0;
    n_checks++;
    if (g_dut[3].bus.o_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_in_flight: got %b, expected 1", g_dut[3].bus.o_busy);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({g_dut[1].bus.o_valid, g_dut[1].bus.o_busy, g_dut[1].bus.o_ovf, g_dut[1].bus.o_arith_out} !== 12'd0) begin
      n_fail++;
      $display("FAIL async_reset: got valid=%b busy=%b ovf=%b out=%h, expected all 0",
               g_dut[1].bus.o_valid, g_dut[1].bus.o_busy, g_dut[1].bus.o_ovf, g_dut[1].bus.o_arith_out);
    end
    n_checks++;
    if ({g_dut[3].bus.o_busy, bus16.o_busy, bus16.o_valid, bus16.o_arith_out} !== 20'd0) begin
      n_fail++;
      $display("FAIL async_reset_deep: got busy8=%b busy16=%b valid16=%b out16=%h, expected all 0",
               g_dut[3].bus.o_busy, bus16.o_busy, bus16.o_valid, bus16.o_arith_out);
    end
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    // nothing may emerge after release
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_checks++;
      if (g_dut[1].bus.o_valid !== 1'b0 || g_dut[3].bus.o_valid !== 1'b0 || bus16.o_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL ghost_output: got valid2=%b valid8=%b valid16=%b, expected 0",
                 g_dut[1].bus.o_valid, g_dut[3].bus.o_valid, bus16.o_valid);
      end
    end
  endtask

  task automatic test_add_sub;
    logic [7:0] ta [6] = '{8'hFF, 8'h7F, 8'h80, 8'h05, 8'h80, 8'h00};
    logic [7:0] tb [6] = '{8'h01, 8'h01, 8'h80, 8'h07, 8'h01, 8'h00};
    logic       tc [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic       ts [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [8:0] eo [6] = '{9'h100, 9'h080, 9'h101, 9'h1FE, 9'h07E, 9'h1FF};
    logic       ev [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    int lat;
    drv_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive_op(ta[i], tb[i], tc[i], ts[i]);
      lat = 0;
      do begin
        @(negedge clk);
        lat++;
      end while (g_dut[1].bus.o_valid !== 1'b1 && lat < 10);
      n_checks++;
      if (g_dut[1].bus.o_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL vec%0d_timeout: got no o_valid, expected result", i);
      end
      n_checks++;
      if (lat != 2) begin
        n_fail++;
        $display("FAIL vec%0d_latency: got %0d cycles, expected 2", i, lat);
      end
      n_checks++;
      if (g_dut[1].bus.o_arith_out !== eo[i] || g_dut[1].bus.o_ovf !== ev[i]) begin
        n_fail++;
        $display("FAIL vec%0d_value: got out=%h ovf=%b, expected out=%h ovf=%b", i,
                 g_dut[1].bus.o_arith_out, g_dut[1].bus.o_ovf, eo[i], ev[i]);
      end
      repeat (8) @(posedge clk);
    end
  endtask

  task automatic test_carry_chain;
    logic [15:0] ta [3] = '{16'hFFFF, 16'h0000, 16'h7FFF};
    logic [15:0] tb [3] = '{16'h0000, 16'h0000, 16'h0000};
    logic        tc [3] = '{1'b1, 1'b1, 1'b1};
    logic        ts [3] = '{1'b0, 1'b1, 1'b0};
    logic [16:0] eo [3] = '{17'h10000, 17'h1FFFF, 17'h08000};
    logic        ev [3] = '{1'b0, 1'b0, 1'b1};
    int lat;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      d16_valid = 1'b1; d16_a = ta[i]; d16_b = tb[i]; d16_c = tc[i]; d16_sub = ts[i];
      @(posedge clk); #1;
      d16_valid = 1'b0;
      lat = 0;
      do begin
        @(negedge clk);
        lat++;
      end while (bus16.o_valid !== 1'b1 && lat < 12);
      n_checks++;
      if (bus16.o_valid !== 1'b1 || lat != 4) begin
        n_fail++;
        $display("FAIL chain%0d_latency: got valid=%b after %0d cycles, expected valid=1 after 4",
                 i, bus16.o_valid, lat);
      end
      n_checks++;
      if (bus16.o_arith_out !== eo[i] || bus16.o_ovf !== ev[i]) begin
        n_fail++;
        $display("FAIL chain%0d_value: got out=%h ovf=%b, expected out=%h ovf=%b", i,
                 bus16.o_arith_out, bus16.o_ovf, eo[i], ev[i]);
      end
      repeat (6) @(posedge clk);
    end
    // random 16-bit operations against the model
    for (int i = 0; i < 8; i++) begin
      logic [17:0] e;
      @(posedge clk); #1;
      d16_valid = 1'b1; d16_a = 16'($urandom); d16_b = 16'($urandom);
      d16_c = 1'($urandom_range(0, 1)); d16_sub = 1'($urandom_range(0, 1));
      e = ref_model(16, d16_a, d16_b, d16_c, d16_sub);
      @(posedge clk); #1;
      d16_valid = 1'b0;
      repeat (4) @(negedge clk);
      n_checks++;
      if (bus16.o_valid !== 1'b1 || {bus16.o_ovf, bus16.o_arith_out} !== e) begin
        n_fail++;
        $display("FAIL chain_rand%0d: got valid=%b val=%h, expected valid=1 val=%h", i,
                 bus16.o_valid, {bus16.o_ovf, bus16.o_arith_out}, e);
      end
    end
  endtask

  task automatic test_back_to_back;
    int base [4];
    base[0] = g_dut[0].out_cnt; base[1] = g_dut[1].out_cnt;
    base[2] = g_dut[2].out_cnt; base[3] = g_dut[3].out_cnt;
    drv_ready = 1'b1;
    for (int i = 0; i < 18; i++) begin
      @(posedge clk); #1;
      drv_valid = (i < 16);
      drive_rand();
      @(negedge clk);
      if (i >= 2) begin
        n_checks++;
        if (g_dut[1].bus.o_valid !== 1'b1) begin
          n_fail++;
          $display("FAIL b2b_stream cycle %0d: got o_valid=%b, expected 1", i, g_dut[1].bus.o_valid);
        end
      end
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++;
    if (g_dut[1].bus.o_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_tail: got o_valid=%b, expected 0", g_dut[1].bus.o_valid);
    end
    repeat (10) @(posedge clk);
    for (int k = 0; k < 4; k++) begin
      int got;
      case (k)
        0: got = g_dut[0].out_cnt - base[0];
        1: got = g_dut[1].out_cnt - base[1];
        2: got = g_dut[2].out_cnt - base[2];
        default: got = g_dut[3].out_cnt - base[3];
      endcase
      n_checks++;
      if (got != 16) begin
        n_fail++;
        $display("FAIL b2b_count ns=%0d: got %0d results, expected 16", 1 << k, got);
      end
    end
  endtask

  task automatic test_backpressure;
    int hold;
    hold = 0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      drv_valid = ($urandom_range(0, 3) != 0);
      drive_rand();
      if (i == 100 || i == 200) hold = 5;
      if (hold > 0) begin
        drv_ready = 1'b0;
        hold--;
      end else begin
        drv_ready = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      if (!drv_ready && g_dut[1].bus.o_valid === 1'b1) begin
        n_checks++;
        if (g_dut[1].bus.o_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL bp_ready cycle %0d: got o_ready=%b, expected 0", i, g_dut[1].bus.o_ready);
        end
      end
    end
    @(posedge clk); #1;
    drv_valid = 1'b0;
    drv_ready = 1'b1;
    repeat (12) @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (g_dut[0].pending != 0 || g_dut[1].pending != 0 ||
        g_dut[2].pending != 0 || g_dut[3].pending != 0) begin
      n_fail++;
      $display("FAIL bp_drain: got pending %0d/%0d/%0d/%0d, expected 0/0/0/0",
               g_dut[0].pending, g_dut[1].pending, g_dut[2].pending, g_dut[3].pending);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_add_sub();
    test_carry_chain();
    test_back_to_back();
    test_backpressure();
    repeat (4) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
